// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_DATA_W   = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'hBFC0_0000;

  // Request tracking: idle, one live request, one killed request awaiting its response.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  // Fetch-queue entry layout at the default data width.
  typedef struct packed {
    logic [FETCH_DATA_W-1:0] instr;
    logic [FETCH_DATA_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] pc_plus4;
    logic                    pred_taken;
    logic [FETCH_DATA_W-1:0] pred_target;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous circular FIFO with push, pop, flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned     PtrW   = $clog2(DEPTH);
  localparam int unsigned     CntW   = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == DepthC);
  // Flush wins over any push or pop in the same cycle.
  assign do_push     = push_i && !flush_i;
  assign do_pop      = pop_i && !empty_o && !flush_i;
  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

`ifndef SYNTHESIS
  // The producer must never push into a full queue unless it pops in the same cycle.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push_i && full_o && !pop_i && !flush_i));
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one ICache request in flight,
// steers on BPU predictions and HDU redirects, and buffers results for decode.
// Optional macro FETCH_BYPASS_EN: a response arriving at an empty queue is
// presented on out_* in the same cycle and skips the queue if decode takes it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       DATA_W   = FETCH_DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(FETCH_RESET_PC),
  parameter int unsigned       FQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      redirect_valid,
  input  logic [DATA_W-1:0]         redirect_addr,
  output logic [DATA_W-1:0]         bpu_pc,
  input  logic                      bpu_taken,
  input  logic [DATA_W-1:0]         bpu_target,
  output logic                      ic_req_valid,
  output logic [DATA_W-1:0]         ic_req_addr,
  input  logic                      ic_req_ready,
  input  logic                      ic_resp_valid,
  input  logic [DATA_W-1:0]         ic_resp_instr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_instr,
  output logic [DATA_W-1:0]         out_pc,
  output logic [DATA_W-1:0]         out_pc_plus4,
  output logic                      out_pred_taken,
  output logic [DATA_W-1:0]         out_pred_target,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus4;
    logic              pred_taken;
    logic [DATA_W-1:0] pred_target;
  } entry_t;

  fetch_state_e      state_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] infl_pc_q;
  logic              infl_taken_q;
  logic [DATA_W-1:0] infl_target_q;

  logic   fq_empty, fq_full;
  logic   req_ok, req_fire, resp_live, byp, push;
  entry_t resp_entry, head_entry, out_entry;

  // A request needs credit for its eventual push; a same-cycle pop is not counted.
  assign req_ok       = (state_q == S_IDLE) && !redirect_valid && !fq_full;
  assign req_fire     = req_ok && ic_req_ready;
  assign ic_req_valid = req_ok && rst_n;
  assign ic_req_addr  = pc_q;
  assign bpu_pc       = pc_q;

  // Only a response to a live request, not coinciding with a redirect, is kept.
  assign resp_live = (state_q == S_WAIT) && ic_resp_valid && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign byp = resp_live && fq_empty;
`else
  assign byp = 1'b0;
`endif

  assign push = resp_live && !(byp && out_ready);

  assign resp_entry = '{
    instr:       ic_resp_instr,
    pc:          infl_pc_q,
    pc_plus4:    infl_pc_q + DATA_W'(4),
    pred_taken:  infl_taken_q,
    pred_target: infl_target_q
  };

  // PC steering, inflight capture and request-state tracking; redirect has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      infl_pc_q     <= '0;
      infl_taken_q  <= 1'b0;
      infl_target_q <= '0;
    end else if (redirect_valid) begin
      pc_q <= redirect_addr;
      unique case (state_q)
        S_WAIT:  state_q <= ic_resp_valid ? S_IDLE : S_DRAIN;
        S_DRAIN: if (ic_resp_valid) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_fire) begin
            infl_pc_q     <= pc_q;
            infl_taken_q  <= bpu_taken;
            infl_target_q <= bpu_target;
            pc_q          <= bpu_taken ? bpu_target : pc_q + DATA_W'(4);
            state_q       <= S_WAIT;
          end
        end
        S_WAIT:  if (ic_resp_valid) state_q <= S_IDLE;
        S_DRAIN: if (ic_resp_valid) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH(FQ_DEPTH),
    .WIDTH($bits(entry_t))
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_valid),
    .push_i     (push),
    .push_data_i(resp_entry),
    .pop_i      (out_ready),
    .head_data_o(head_entry),
    .empty_o    (fq_empty),
    .full_o     (fq_full),
    .count_o    (fq_count)
  );

  // Present the queue head, or the bypassed response when the queue is empty.
  always_comb begin
    out_entry = head_entry;
    if (byp) out_entry = resp_entry;
  end

  assign out_valid       = !fq_empty || byp;
  assign out_instr       = out_entry.instr;
  assign out_pc          = out_entry.pc;
  assign out_pc_plus4    = out_entry.pc_plus4;
  assign out_pred_taken  = out_entry.pred_taken;
  assign out_pred_target = out_entry.pred_target;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk, rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [31:0] bpu_pc;
  logic        bpu_taken;
  logic [31:0] bpu_target;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_instr;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc, out_pc_plus4, out_pred_target;
  logic        out_pred_taken;
  logic [2:0]  fq_count;

  fetch_unit #(
    .DATA_W  (32),
    .RESET_PC(32'hBFC0_0000),
    .FQ_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bpu_pc         (bpu_pc),
    .bpu_taken      (bpu_taken),
    .bpu_target     (bpu_target),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_instr  (ic_resp_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_pred_taken (out_pred_taken),
    .out_pred_target(out_pred_target),
    .fq_count       (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass, n_total;

  // Reference model: PC, request status (0 none, 1 live, 2 killed), inflight info, queue.
  logic [31:0] m_pc;
  int          m_st;
  fq_entry_t   m_infl;
  fq_entry_t   m_q[$];

  // ICache and stimulus knobs (0/1 fixed, 2 random).
  int          resp_cnt;
  logic [31:0] resp_word;
  int          k_req_ready, k_out_ready, k_lat_min, k_lat_max, k_bpu_mode, k_red_pct;
  logic [31:0] k_hit_pc, k_hit_target;
  bit          red_pend;
  logic [31:0] red_addr;

  logic [31:0] req_log[$];
  fq_entry_t   pop_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic pick(input int k);
    return (k == 2) ? 1'($urandom % 2) : (k != 0);
  endfunction

  task automatic model_reset();
    m_pc   = 32'hBFC0_0000;
    m_st   = 0;
    m_infl = '0;
    m_q.delete();
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle();
    bit        exp_req, byp, exp_ov, hs;
    int        sz;
    fq_entry_t e;
    fq_entry_t ne;
    ic_req_ready = pick(k_req_ready);
    out_ready    = pick(k_out_ready);
    if (red_pend) begin
      redirect_valid = 1'b1;
      redirect_addr  = red_addr;
      red_pend       = 1'b0;
    end else if (k_red_pct > 0 && int'($urandom % 100) < k_red_pct) begin
      redirect_valid = 1'b1;
      redirect_addr  = $urandom & 32'hFFFF_FFFC;
    end else begin
      redirect_valid = 1'b0;
    end
    ic_resp_valid = (resp_cnt == 1);
    ic_resp_instr = (resp_cnt == 1) ? resp_word : $urandom;
    case (k_bpu_mode)
      1: begin bpu_taken = (bpu_pc == k_hit_pc); bpu_target = k_hit_target; end
      2: begin
        bpu_taken  = ($urandom % 4 == 0);
        bpu_target = ($urandom % 8 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      end
      default: begin bpu_taken = 1'b0; bpu_target = $urandom; end
    endcase
    #2;
    sz      = m_q.size();
    exp_req = (m_st == 0) && !redirect_valid && (sz < DEPTH);
    byp     = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp = (sz == 0) && (m_st == 1) && ic_resp_valid && !redirect_valid;
`endif
    exp_ov = (sz > 0) || byp;
    e = '0;
    if (byp) e = '{ic_resp_instr, m_infl.pc, m_infl.pc + 32'd4, m_infl.pred_taken,
                   m_infl.pred_target};
    else if (sz > 0) e = m_q[0];
    chk("bpu_pc", bpu_pc, m_pc);
    chk("ic_req_addr", ic_req_addr, m_pc);
    chk("ic_req_valid", ic_req_valid, exp_req);
    chk("out_valid", out_valid, exp_ov);
    chk("fq_count", fq_count, sz);
    if (exp_ov) begin
      chk("out_instr", out_instr, e.instr);
      chk("out_pc", out_pc, e.pc);
      chk("out_pc_plus4", out_pc_plus4, e.pc_plus4);
      chk("out_pred_taken", out_pred_taken, e.pred_taken);
      chk("out_pred_target", out_pred_target, e.pred_target);
    end
    hs = ic_req_valid && ic_req_ready;
    if (hs) req_log.push_back(ic_req_addr);
    if (out_valid && out_ready)
      pop_log.push_back('{out_instr, out_pc, out_pc_plus4, out_pred_taken, out_pred_target});
    @(posedge clk);
    if (redirect_valid) begin
      m_pc = redirect_addr;
      m_q.delete();
      if (m_st == 1) m_st = ic_resp_valid ? 0 : 2;
      else if (m_st == 2 && ic_resp_valid) m_st = 0;
    end else begin
      if (sz > 0 && out_ready) void'(m_q.pop_front());
      if (m_st == 0 && exp_req && ic_req_ready) begin
        m_infl = '{32'd0, m_pc, m_pc + 32'd4, bpu_taken, bpu_target};
        m_pc   = bpu_taken ? bpu_target : m_pc + 32'd4;
        m_st   = 1;
      end else if (m_st == 1 && ic_resp_valid) begin
        ne = '{ic_resp_instr, m_infl.pc, m_infl.pc + 32'd4, m_infl.pred_taken,
               m_infl.pred_target};
        if (!(byp && out_ready)) m_q.push_back(ne);
        m_st = 0;
      end else if (m_st == 2 && ic_resp_valid) begin
        m_st = 0;
      end
    end
    if (resp_cnt > 0) resp_cnt--;
    if (hs) begin
      resp_cnt  = $urandom_range(k_lat_max, k_lat_min);
      resp_word = $urandom;
    end
    @(negedge clk);
  endtask

  task automatic reset_checks();
    chk("rst_ic_req_valid", ic_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fq_count", fq_count, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_pc_plus4", out_pc_plus4, 0);
    chk("rst_out_pred_taken", out_pred_taken, 0);
    chk("rst_out_pred_target", out_pred_target, 0);
    chk("rst_bpu_pc", bpu_pc, 32'hBFC0_0000);
    chk("rst_ic_req_addr", ic_req_addr, 32'hBFC0_0000);
  endtask

  initial begin
    int n;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_addr = '0; bpu_taken = 1'b0; bpu_target = '0;
    ic_req_ready = 1'b0; ic_resp_valid = 1'b0; ic_resp_instr = '0; out_ready = 1'b0;
    k_req_ready = 1; k_out_ready = 1; k_lat_min = 1; k_lat_max = 1;
    k_bpu_mode = 0; k_red_pct = 0; k_hit_pc = '0; k_hit_target = '0;
    red_pend = 1'b0; red_addr = '0; resp_cnt = 0; resp_word = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    // Sequential fetch from the reset vector.
    repeat (9) cycle();
    chk("seq_req0", (req_log.size() > 0) ? req_log[0] : 32'hx, 32'hBFC0_0000);
    chk("seq_req1", (req_log.size() > 1) ? req_log[1] : 32'hx, 32'hBFC0_0004);
    chk("seq_req2", (req_log.size() > 2) ? req_log[2] : 32'hx, 32'hBFC0_0008);
    chk("seq_pop0", (pop_log.size() > 0) ? pop_log[0].pc : 32'hx, 32'hBFC0_0000);
    chk("seq_pop1", (pop_log.size() > 1) ? pop_log[1].pc : 32'hx, 32'hBFC0_0004);
    chk("seq_pop2", (pop_log.size() > 2) ? pop_log[2].pc : 32'hx, 32'hBFC0_0008);

    // Predicted-taken branch at BFC00004.
    k_bpu_mode = 1; k_hit_pc = 32'hBFC0_0004; k_hit_target = 32'hBFC0_0100;
    red_pend = 1'b1; red_addr = 32'hBFC0_0004;
    cycle();
    req_log.delete(); pop_log.delete();
    repeat (8) cycle();
    chk("bpu_req0", (req_log.size() > 0) ? req_log[0] : 32'hx, 32'hBFC0_0004);
    chk("bpu_req1", (req_log.size() > 1) ? req_log[1] : 32'hx, 32'hBFC0_0100);
    chk("bpu_pop_pc", (pop_log.size() > 0) ? pop_log[0].pc : 32'hx, 32'hBFC0_0004);
    chk("bpu_pop_taken", (pop_log.size() > 0) ? 32'(pop_log[0].pred_taken) : 32'hx, 1);
    chk("bpu_pop_target", (pop_log.size() > 0) ? pop_log[0].pred_target : 32'hx,
        32'hBFC0_0100);
    k_bpu_mode = 0;

    // Fill the queue with decode stalled, then release one entry.
    k_out_ready = 0;
    red_pend = 1'b1; red_addr = 32'h0000_1000;
    cycle();
    req_log.delete();
    repeat (14) cycle();
    chk("full_reqs", req_log.size(), 4);
    chk("full_count", fq_count, 4);
    chk("full_no_req", ic_req_valid, 0);
    k_out_ready = 1;
    cycle();
    k_out_ready = 0;
    chk("pop1_count", fq_count, 3);
    chk("pop1_req_valid", ic_req_valid, 1);
    cycle();
    chk("pop1_reqs", req_log.size(), 5);

    // Redirect while a request is outstanding; its response arrives a cycle later.
    k_out_ready = 1; k_lat_min = 2; k_lat_max = 2;
    n = 0;
    while (!(m_st == 1 && resp_cnt == 2) && n < 30) begin cycle(); n++; end
    chk("c_reach_wait", n < 30, 1);
    red_pend = 1'b1; red_addr = 32'h8000_0000;
    cycle();
    chk("c_flush_count", fq_count, 0);
    chk("c_pc", bpu_pc, 32'h8000_0000);
    req_log.delete(); pop_log.delete();
    repeat (8) cycle();
    chk("c_first_req", (req_log.size() > 0) ? req_log[0] : 32'hx, 32'h8000_0000);
    chk("c_first_pop", (pop_log.size() > 0) ? pop_log[0].pc : 32'hx, 32'h8000_0000);

    // Redirect coinciding with the response.
    k_out_ready = 0; k_lat_min = 1; k_lat_max = 1;
    n = 0;
    while (!(m_st == 1 && resp_cnt == 1) && n < 30) begin cycle(); n++; end
    chk("d_reach_wait", n < 30, 1);
    red_pend = 1'b1; red_addr = 32'h0000_2000;
    cycle();
    chk("d_same_count", fq_count, 0);
    chk("d_same_pc", bpu_pc, 32'h0000_2000);

    // Redirect with a full queue.
    repeat (12) cycle();
    chk("d_full_count", fq_count, 4);
    red_pend = 1'b1; red_addr = 32'h0000_3000;
    cycle();
    chk("d_full_flush", fq_count, 0);
    chk("d_full_pc", bpu_pc, 32'h0000_3000);

    // Reset while a request is in flight.
    k_out_ready = 1;
    n = 0;
    while (m_st != 1 && n < 30) begin cycle(); n++; end
    chk("e_reach_wait", n < 30, 1);
    rst_n = 1'b0; redirect_valid = 1'b0; ic_resp_valid = 1'b0;
    #2;
    reset_checks();
    model_reset();
    resp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    k_req_ready = 2; k_out_ready = 2; k_lat_min = 1; k_lat_max = 3;
    k_bpu_mode = 2; k_red_pct = 4;
    repeat (3000) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
